// File: rtl/approx_sched_pkg.sv
// Shared types for the approximate-adder scheduler: FSM state, data width,
// and the registered response bundle.
package approx_sched_pkg;

  localparam int DATA_W   = 16;
  localparam int MAX_ID_W = 3;  // covers up to 8 requesters

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [DATA_W-1:0]   sum;
    logic                cout;
    logic                err;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last grant and
// advances its pointer only when a grant is actually issued.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx
);

  logic [ID_W-1:0] r_last;
  logic            w_found;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    int j;
    w_found = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(r_last) + k) % N_REQ;
      if (!w_found && i_req[j]) begin
        w_found = 1'b1;
        o_idx   = ID_W'(j);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      o_grant[i] = i_en && w_found && (int'(o_idx) == i);
    end
  end

  // Pointer starts at the last requester so requester 0 wins first after reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= ID_W'(N_REQ - 1);
    end else if (i_en && w_found) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/approx_add_sched.sv
// Shares one external approximate 16-bit adder among N_REQ requesters.
// Optional APPROX_ERR_FLAG_EN adds an exact reference adder and the rsp_err flag.
module approx_add_sched
  import approx_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_cin,
  output logic [DATA_W-1:0]       add_a,
  output logic [DATA_W-1:0]       add_b,
  output logic                    add_cin,
  input  logic [DATA_W-1:0]       add_sum,
  input  logic [DATA_W:0]         add_carry,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_sum,
  output logic                    rsp_cout
`ifdef APPROX_ERR_FLAG_EN
  ,output logic                   rsp_err
`endif
);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_grant_en;
  logic              w_any;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_idx;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_cin;
  logic [ID_W-1:0]   r_id;
  rsp_t              r_rsp;
  rsp_t              w_rsp;
  logic              w_err;
  logic              w_unused;

  assign w_any = |req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = w_any ? EXEC : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A grant slot exists in IDLE, or in RESP when the response is being taken.
  always_comb begin
    w_grant_en = 1'b0;
    rsp_valid  = 1'b0;
    case (r_state)
      IDLE:    w_grant_en = !rst;
      RESP: begin
        rsp_valid  = 1'b1;
        w_grant_en = rsp_ready && !rst;
      end
      default: ;
    endcase
  end

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req_valid),
    .i_en    (w_grant_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign req_ready = w_grant;

  // Operand registers double as the adder drive, so it only moves on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_id  <= '0;
    end else if (w_grant_en && w_any) begin
      r_a   <= req_a[DATA_W*w_idx +: DATA_W];
      r_b   <= req_b[DATA_W*w_idx +: DATA_W];
      r_cin <= req_cin[w_idx];
      r_id  <= w_idx;
    end
  end

  assign add_a   = r_a;
  assign add_b   = r_b;
  assign add_cin = r_cin;

`ifdef APPROX_ERR_FLAG_EN
  logic [DATA_W:0] w_exact;
  assign w_exact = {1'b0, r_a} + {1'b0, r_b} + {{DATA_W{1'b0}}, r_cin};
  assign w_err   = (w_exact != {add_carry[DATA_W], add_sum});
  assign rsp_err = r_rsp.err;
`else
  assign w_err = 1'b0;
`endif

  assign w_rsp = '{id: MAX_ID_W'(r_id), sum: add_sum, cout: add_carry[DATA_W], err: w_err};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_rsp <= '0;
    else if (r_state == EXEC) r_rsp <= w_rsp;
  end

  assign rsp_id   = r_rsp.id[ID_W-1:0];
  assign rsp_sum  = r_rsp.sum;
  assign rsp_cout = r_rsp.cout;

  // Internal carries of the core and spare id/err bits are intentionally ignored.
  assign w_unused = ^{r_rsp.id, r_rsp.err, add_carry[DATA_W-1:0]};

endmodule

// File: tb/tb_approx_add_sched.sv
// Self-checking bench for approx_add_sched with a behavioural approximate core
// and a transaction-level scheduling model.
module tb_approx_add_sched;

  localparam int N    = 2;
  localparam int ID_W = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_cin;
  logic [N*16-1:0] req_a, req_b;
  logic [15:0]     add_a, add_b, add_sum;
  logic            add_cin;
  logic [16:0]     add_carry;
  logic            rsp_valid, rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [15:0]     rsp_sum;
  logic            rsp_cout;
`ifdef APPROX_ERR_FLAG_EN
  logic            rsp_err;
`endif
  logic [16:0]     core_out;

  always #5 clk = ~clk;

  approx_add_sched #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef APPROX_ERR_FLAG_EN
    ,.rsp_err  (rsp_err)
`endif
  );

  // Approximate core: the two low sum bits are dropped together with their
  // carry (and the carry-in); the upper 14 bits add exactly.
  function automatic logic [16:0] core_add(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin_unused);
    logic [14:0] hi;
    hi = {1'b0, a[15:2]} + {1'b0, b[15:2]};
    return {hi, 2'b00};
  endfunction

  function automatic logic [16:0] exact_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
    return {1'b0, a} + {1'b0, b} + 17'(cin);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  assign core_out  = core_add(add_a, add_b, add_cin);
  assign add_sum   = core_out[15:0];
  assign add_carry = {core_out[16], add_a & add_b};

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          m_phase;   // 0 free, 1 computing, 2 response pending
  int          m_last;
  int          m_id;
  logic [15:0] m_a, m_b;
  logic        m_cin;
  logic [16:0] m_core;
  logic        m_err;
  logic [N-1:0] last_ready;
  bit          log_grants = 1'b0;
  int          grant_ids[$];
  int          grant_cycs[$];
  logic [15:0] held_sum;
  logic [ID_W-1:0] held_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_model();
    m_phase = 0;
    m_last  = N - 1;
    m_id    = 0;
    m_a     = '0;
    m_b     = '0;
    m_cin   = 1'b0;
    m_core  = '0;
    m_err   = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i]        = cin;
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic step();
    int          w;
    bit          g_ok;
    logic [N-1:0] exp_ready;
    #1;
    g_ok = (m_phase == 0) || (m_phase == 2 && rsp_ready);
    w = g_ok ? rr_pick(req_valid, m_last) : -1;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      check("rsp_id",   32'(rsp_id),   32'(m_id));
      check("rsp_sum",  32'(rsp_sum),  32'(m_core[15:0]));
      check("rsp_cout", 32'(rsp_cout), 32'(m_core[16]));
`ifdef APPROX_ERR_FLAG_EN
      check("rsp_err",  32'(rsp_err),  32'(m_err));
`endif
    end
    check("add_a",   32'(add_a),   32'(m_a));
    check("add_b",   32'(add_b),   32'(m_b));
    check("add_cin", 32'(add_cin), 32'(m_cin));
    last_ready = req_ready;
    if (log_grants && req_ready != '0) begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          grant_ids.push_back(i);
          grant_cycs.push_back(cyc);
        end
      end
    end
    @(posedge clk);
    if (w >= 0) begin
      m_last  = w;
      m_id    = w;
      m_a     = req_a[16*w +: 16];
      m_b     = req_b[16*w +: 16];
      m_cin   = req_cin[w];
      m_core  = core_add(m_a, m_b, m_cin);
      m_err   = (m_core != exact_add(m_a, m_b, m_cin));
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && rsp_ready) begin
      m_phase = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    reset_model();

    // Reset values, with requests pending to show req_ready stays low.
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_id",    32'(rsp_id),    32'(0));
    check("rst_rsp_sum",   32'(rsp_sum),   32'(0));
    check("rst_rsp_cout",  32'(rsp_cout),  32'(0));
    check("rst_add_a",     32'(add_a),     32'(0));
`ifdef APPROX_ERR_FLAG_EN
    check("rst_rsp_err",   32'(rsp_err),   32'(0));
`endif
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;

    // Single request, latency G+2.
    set_req(0, 16'h0100, 16'h0200, 1'b0);
    req_valid = 2'b01;
    step();
    check("t1_grant", 32'(last_ready), 32'(2'b01));
    req_valid = '0;
    check("t1_g1_valid", 32'(rsp_valid), 32'(0));
    step();
    check("t1_g2_valid", 32'(rsp_valid), 32'(1));
    check("t1_id",       32'(rsp_id),    32'(0));
    check("t1_sum",      32'(rsp_sum),   32'(16'h0300));
    check("t1_cout",     32'(rsp_cout),  32'(0));
`ifdef APPROX_ERR_FLAG_EN
    check("t1_err",      32'(rsp_err),   32'(0));
`endif
    step();

    // Low-carry loss reported as the core computes it.
    set_req(0, 16'h003F, 16'h0001, 1'b0);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    step();
    check("t2_sum", 32'(rsp_sum), 32'(16'h003C));
`ifdef APPROX_ERR_FLAG_EN
    check("t2_err", 32'(rsp_err), 32'(1));
`endif
    step();

    // Overflow from requester 1.
    set_req(1, 16'hFF00, 16'h0100, 1'b0);
    req_valid = 2'b10;
    step();
    req_valid = '0;
    step();
    check("t3_id",   32'(rsp_id),   32'(1));
    check("t3_sum",  32'(rsp_sum),  32'(16'h0000));
    check("t3_cout", 32'(rsp_cout), 32'(1));
    step();

    // Fairness: both requesters continuously valid.
    set_req(0, 16'h1111, 16'h2222, 1'b1);
    set_req(1, 16'h4444, 16'h8888, 1'b0);
    req_valid = 2'b11;
    grant_ids.delete();
    grant_cycs.delete();
    log_grants = 1'b1;
    repeat (11) step();
    log_grants = 1'b0;
    req_valid = '0;
    repeat (2) step();
    check("fair_count", 32'(grant_ids.size()), 32'(6));
    for (int i = 0; i < grant_ids.size() && i < 6; i++) begin
      check("fair_id", 32'(grant_ids[i]), 32'(i % 2));
      if (i > 0) check("fair_gap", 32'(grant_cycs[i] - grant_cycs[i-1]), 32'(2));
    end

    // Backpressure for five cycles, then a same-cycle grant on release.
    set_req(0, 16'hA5A5, 16'h0F0F, 1'b1);
    set_req(1, 16'h1357, 16'h2468, 1'b1);
    req_valid = 2'b11;
    step();
    step();
    rsp_ready = 1'b0;
    held_sum  = rsp_sum;
    held_id   = rsp_id;
    repeat (5) step();
    check("bp_sum_held", 32'(rsp_sum), 32'(held_sum));
    check("bp_id_held",  32'(rsp_id),  32'(held_id));
    rsp_ready = 1'b1;
    step();
    check("bp_release_grant", 32'(last_ready), 32'(2'b10));
    req_valid = '0;
    repeat (2) step();

    // Reset while an operation from requester 0 is in EXEC.
    set_req(0, 16'h1234, 16'h4321, 1'b1);
    req_valid = 2'b01;
    step();
    rst = 1'b1;
    #1;
    check("rx_req_ready", 32'(req_ready), 32'(0));
    check("rx_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rx_add_a",     32'(add_a),     32'(0));
    check("rx_add_b",     32'(add_b),     32'(0));
    check("rx_add_cin",   32'(add_cin),   32'(0));
    check("rx_rsp_id",    32'(rsp_id),    32'(0));
    check("rx_rsp_sum",   32'(rsp_sum),   32'(0));
    check("rx_rsp_cout",  32'(rsp_cout),  32'(0));
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    req_valid = 2'b11;
    step();
    check("rx_first_grant", 32'(last_ready), 32'(2'b01));

    // Randomized traffic against the model.
    repeat (400) begin
      req_valid = N'($urandom);
      req_a     = ($urandom << 16) | $urandom_range(0, 16'hFFFF);
      req_b     = ($urandom << 16) | $urandom_range(0, 16'hFFFF);
      req_cin   = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/approx_add_sched.md
# approx_add_sched

Round-robin scheduler sharing one 16-bit approximate Brent-Kung adder core among N_REQ requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester, drives the shared adder, registers its result, and returns it tagged with the requester id over a backpressured response channel. It sits between the client datapaths and the single adder instance; the adder itself stays outside this block.

## Interface
- N_REQ, 2: number of requesters, 2..8.
- ID_W, $clog2(N_REQ): response id width.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_a  in  N_REQ*16  packed operand A; requester i at [16*i+15:16*i].
- req_b  in  N_REQ*16  packed operand B.
- req_cin  in  N_REQ  carry-in per requester.
- add_a  out  16  to adder A.
- add_b  out  16  to adder B.
- add_cin  out  1  to adder carry-in.
- add_sum  in  16  from adder sum.
- add_carry  in  17  from adder carry vector; bit 16 is carry-out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  granted requester index.
- rsp_sum  out  16  registered sum.
- rsp_cout  out  1  registered add_carry[16].
- rsp_err  out  1  mismatch flag; present only with the macro below.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, assert req_ready for the round-robin winner.
  - Latch its a/b/cin into operand registers and its index into id_q.
  - Go to EXEC.
- EXEC, exactly one cycle:
  - add_a/add_b/add_cin are driven from the operand registers.
  - At the end of the cycle, capture add_sum and add_carry[16] into the response registers.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_* are held stable until rsp_ready.
  - On rsp_ready with any req_valid high: grant the next winner in the same cycle and go to EXEC (back-to-back).
  - On rsp_ready with no request: go to IDLE.
- Round robin:
  - Search starts at (last_grant+1) mod N_REQ.
  - Pointer updates only on a grant.
  - After reset, requester 0 has highest priority.
- req_ready is combinational from state, req_valid and the pointer. It is high only in IDLE, or in RESP together with rsp_ready.
- The adder drive is held at the last operands outside EXEC. There are no spurious changes.
- Arithmetic is as computed by the core: no correction, and the adder's carry-in handling is passed through unchanged.

## Timing
- Latency: grant cycle G, response valid from cycle G+2.
- Throughput: one operation per 2 cycles when rsp_ready is held high.
- Reset values:
  - state=IDLE, req_ready=0.
  - add_a=0, add_b=0, add_cin=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_err=0.
  - Pointer set so requester 0 wins first.
- Reset mid-operation: the in-flight transaction is dropped and no response is issued.
- A requester may drop req_valid before it is granted; it loses nothing.
- Simultaneous requests: exactly one grant per grant cycle.
- The N_REQ-1 to 0 wrap-around is covered by the pointer mod.

## Configuration
- APPROX_ERR_FLAG_EN defined:
  - In EXEC, the block also computes the exact 17-bit {cout,sum} = a+b+cin.
  - rsp_err=1 when the adder's {add_carry[16],add_sum} differs from the exact value; registered with the response.
- APPROX_ERR_FLAG_EN undefined: the rsp_err port and the exact adder are absent.

## Structure
- Package approx_sched_pkg:
  - state enum {IDLE, EXEC, RESP}.
  - localparam DATA_W=16.
  - Packed response struct {id, sum, cout, err}.
- Sub-module rr_arbiter:
  - Inputs: N_REQ request vector, enable.
  - Outputs: one-hot grant and encoded index.
  - Owns the priority pointer.

## Test plan
- Single request: req0 with a=0x0100, b=0x0200, cin=0, granted at cycle G → rsp_valid at G+2, rsp_id=0, rsp_sum=0x0300, rsp_cout=0, rsp_err=0.
- Low-carry loss: a=0x003F, b=0x0001 → rsp_sum=0x003C (core output), rsp_err=1 with the macro.
- Overflow: a=0xFF00, b=0x0100 → rsp_sum=0x0000, rsp_cout=1.
- Fairness: both requesters valid continuously for 6 grants with rsp_ready=1 → ids 0,1,0,1,0,1, one grant every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* held stable, req_ready=0; on release the next grant happens in the same cycle.
- Reset in EXEC: assert rst → all outputs return to their reset values immediately, no response for the dropped operation, first post-reset grant goes to requester 0.
